cordic_pipe: RTL and testbench
==============================

# cordic_pipe

Parametrised, fully pipelined CORDIC engine. It supports both rotation mode (sine/cosine, vector rotation) and vectoring mode (magnitude/phase), with the mode selected per sample. It accepts one sample per clock with a valid qualifier and covers the full ±180° range through a quadrant pre-rotation stage. It replaces the fixed 16-bit, rotation-only pipeline in the DSP datapath.

## Interface
Parameters:
- `WIDTH`, 16: signed width of `x_in`/`y_in`.
- `ANGLE_W`, 16: signed angle width; full circle = 2^ANGLE_W (0x2000 = 45° at 16 bits); legal range 8..32.
- `STAGES`, 16: number of micro-rotation stages; legal range 4..24.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: sample on the inputs is valid this cycle.
- `mode`  in  1: 0 = rotation, 1 = vectoring; captured with the sample.
- `x_in`, `y_in`  in  WIDTH each: signed input vector.
- `z_in`  in  ANGLE_W: signed angle; used in rotation mode, added as an offset in vectoring mode.
- `out_valid`  out  1: result valid.
- `mode_out`  out  1: mode of the emerging sample.
- `x_out`, `y_out`  out  WIDTH+2 each: signed results with 2 guard bits.
- `z_out`  out  ANGLE_W: signed residual or accumulated angle.

## Operation
- No backpressure: every `in_valid` sample emerges exactly once, in order, after a fixed latency.
- Internal x/y width is WIDTH+2. Inputs are sign-extended. All adds wrap at the internal width; the 2 guard bits prevent overflow for any input.
- Stage Q (quadrant pre-rotation):
  - Rotation mode:
    - z top bits 01 → x'=−y, y'=x, z'=z−90°.
    - z top bits 10 → x'=y, y'=−x, z'=z+90°.
    - Otherwise pass through.
  - Vectoring mode, x<0:
    - y≥0 → x'=y, y'=−x, z'=z+90°.
    - y<0 → x'=−y, y'=x, z'=z−90°.
  - Vectoring mode, x≥0: pass through.
- Stage i (0..STAGES−1), direction d:
  - Rotation: d=+1 if z≥0, else −1.
  - Vectoring: d=+1 if y<0, else −1.
  - Update: x←x−d·(y>>>i); y←y+d·(x>>>i); z←z−d·atan(2^−i).
- atan table: 24 constants held as 32-bit values (full circle = 2^32), reduced to ANGLE_W by a rounded right shift of 32−ANGLE_W. Entries that round to 0 are legal.
- Results:
  - Rotation: x_out=K·(x cosθ − y sinθ), y_out=K·(x sinθ + y cosθ), z_out≈0.
  - Vectoring: x_out=K·|v|, y_out≈0, z_out=z_in+atan2(y_in,x_in).
  - K≈1.64676, or 1 when gain compensation is compiled in.
- `mode` and `valid` travel with the data through every stage.
- Reset: all valid bits, data registers and outputs are 0. Samples in flight when reset is asserted are discarded and never reported.

## Timing
- Latency L = STAGES+1 clocks from `in_valid` to `out_valid` without compensation; STAGES+2 with it. This counts the Q stage plus STAGES micro-rotation stages, with the final stage registered as the output.
- Throughput: 1 sample/clock. Back-to-back and gapped inputs both produce the same valid pattern, delayed by L.
- Reset is sampled at the clock edge. `out_valid`=0 from the first edge with `reset` high.
  - The first post-reset input (reset low) appears L edges later.
  - A sample presented in the same cycle as `reset` is dropped.
- Outputs are registered and held until the next edge. They are not zeroed when `out_valid`=0 after the first result.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - Adds one registered stage after the last micro-rotation.
  - The stage multiplies x and y by 1/K = 19898/32768 (Q1.15) and rounds half-up.
  - Latency is STAGES+2.
  - Results are unit-gain.
- `CORDIC_GAIN_COMP_EN` undefined:
  - No multiplier.
  - Latency is STAGES+1.
  - x/y results carry gain K.
- z handling is identical in both builds.

## Test plan
Defaults: WIDTH=16, ANGLE_W=16, STAGES=16, `CORDIC_GAIN_COMP_EN` defined.
- Rotation, x_in=10000, y_in=0, z_in=0x2000 (45°) → x_out, y_out = 7071±4; |z_out|≤2; `out_valid` exactly 18 cycles after `in_valid`. Without the macro: x_out, y_out = 11644±6, latency 17.
- Rotation, x_in=10000, y_in=0, z_in=0x6000 (135°) → x_out=−7071±4, y_out=7071±4. Repeat at z_in=0x8000 (−180°) → x_out=−10000±4, y_out=0±4.
- Vectoring, x_in=−3000, y_in=4000, z_in=0 → x_out=5000±4, |y_out|≤4, z_out=0x5A38±3 (126.87°).
- Throughput: 40 consecutive samples alternating mode, then 3 idle, then 5 samples → `out_valid` pattern identical, shifted by 18; each `mode_out` matches its input.
- Reset mid-stream: assert `reset` for 1 cycle while 10 samples are in flight → no result from those samples; outputs 0 the cycle after reset; the next sample emerges 18 cycles after it is presented.
- Extremes: x_in=−32768, y_in=−32768, vectoring → no wrap; x_out=46341±8, z_out=−0x6000±3 (−135°).

Source files
------------

// File: rtl/cordic_pipe.sv
// cordic_pipe: pipelined rotation/vectoring CORDIC with quadrant pre-rotation; define CORDIC_GAIN_COMP_EN for a unit-gain 1/K output stage
module cordic_pipe #(
  parameter int WIDTH = 16,
  parameter int ANGLE_W = 16,
  parameter int STAGES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      mode,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                      out_valid,
  output logic                      mode_out,
  output logic signed [WIDTH+1:0]   x_out,
  output logic signed [WIDTH+1:0]   y_out,
  output logic signed [ANGLE_W-1:0] z_out
);
  localparam int IW = WIDTH + 2;
  localparam int SH = 32 - ANGLE_W;
  localparam logic [31:0] ATAN32 [0:23] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };
  localparam logic signed [ANGLE_W-1:0] QTR = {2'b01, {(ANGLE_W-2){1'b0}}};
  function automatic logic signed [ANGLE_W-1:0] atan_at(input logic [4:0] i);
    logic [33:0] r;
    r = {1'b0, ATAN32[i], 1'b0} + (34'd1 << SH);
    return ANGLE_W'(r >> (SH + 1));
  endfunction
  logic signed [IW-1:0] xs [0:STAGES];
  logic signed [IW-1:0] ys [0:STAGES];
  logic signed [IW-1:0] nx [0:STAGES];
  logic signed [IW-1:0] ny [0:STAGES];
  logic signed [ANGLE_W-1:0] zs [0:STAGES];
  logic signed [ANGLE_W-1:0] nz [0:STAGES];
  logic [STAGES:0] vs, ms, nv, nm;
  logic signed [IW-1:0] xe, ye;
  logic up, dn, dp;
  always_comb begin
    xe = {{2{x_in[WIDTH-1]}}, x_in};
    ye = {{2{y_in[WIDTH-1]}}, y_in};
    up = mode ? (x_in[WIDTH-1] & y_in[WIDTH-1]) : (z_in[ANGLE_W-1 -: 2] == 2'b01);
    dn = mode ? (x_in[WIDTH-1] & ~y_in[WIDTH-1]) : (z_in[ANGLE_W-1 -: 2] == 2'b10);
    nx[0] = up ? -ye : dn ? ye : xe;
    ny[0] = up ? xe : dn ? -xe : ye;
    nz[0] = up ? z_in - QTR : dn ? z_in + QTR : z_in;
    nv = {vs[STAGES-1:0], in_valid};
    nm = {ms[STAGES-1:0], mode};
    dp = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      dp = ms[i] ? ys[i][IW-1] : ~zs[i][ANGLE_W-1];
      nx[i+1] = dp ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
      ny[i+1] = dp ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
      nz[i+1] = dp ? zs[i] - atan_at(5'(i)) : zs[i] + atan_at(5'(i));
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      vs <= '0;
      ms <= '0;
      xs <= '{default: '0};
      ys <= '{default: '0};
      zs <= '{default: '0};
    end else begin
      vs <= nv;
      ms <= nm;
      xs <= nx;
      ys <= ny;
      zs <= nz;
    end
`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = IW + 16;
  logic signed [PW-1:0] px, py;
  always_comb begin
    px = PW'(xs[STAGES]) * PW'(19898) + PW'(16384);
    py = PW'(ys[STAGES]) * PW'(19898) + PW'(16384);
  end
  always_ff @(posedge clock)
    if (reset) begin
      out_valid <= 1'b0;
      mode_out <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
    end else begin
      out_valid <= vs[STAGES];
      mode_out <= ms[STAGES];
      x_out <= IW'(px >>> 15);
      y_out <= IW'(py >>> 15);
      z_out <= zs[STAGES];
    end
`else
  assign out_valid = vs[STAGES];
  assign mode_out = ms[STAGES];
  assign x_out = xs[STAGES];
  assign y_out = ys[STAGES];
  assign z_out = zs[STAGES];
`endif
endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: scoreboard bench comparing cordic_pipe against real-arithmetic trigonometry
module tb_cordic_pipe;
  localparam int W = 16;
  localparam int AW = 16;
  localparam int ST = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int L = ST + 2;
  localparam real G = 1.0;
  localparam real TS = 1.0;
`else
  localparam int L = ST + 1;
  localparam real G = 1.6467602581;
  localparam real TS = 1.5;
`endif
  localparam real PI = 3.14159265358979;
  localparam real UNIT = 65536.0 / (2.0 * PI);
  logic clock = 0, reset = 1, in_valid = 0, mode = 0;
  logic signed [W-1:0] x_in = 0, y_in = 0;
  logic signed [AW-1:0] z_in = 0;
  logic out_valid, mode_out;
  logic signed [W+1:0] x_out, y_out;
  logic signed [AW-1:0] z_out;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct { bit m; real x, y, z, txy, tz; int t; } exp_t;
  exp_t sb[$];
  cordic_pipe #(.WIDTH(W), .ANGLE_W(AW), .STAGES(ST)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .mode_out(mode_out),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input bit ok, input real act, input real req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0.2f expected %0.2f (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic real wrap(input real d);
    real r = d;
    while (r >= 32768.0) r -= 65536.0;
    while (r < -32768.0) r += 65536.0;
    return r;
  endfunction
  function automatic real absr(input real d);
    return d < 0.0 ? -d : d;
  endfunction
  task automatic issue(input bit m, input int x, input int y, input int z, input real txy, input real tz);
    exp_t e;
    real a, rx, ry;
    mode = m;
    x_in = W'(x);
    y_in = W'(y);
    z_in = AW'(z);
    in_valid = 1;
    rx = real'(x);
    ry = real'(y);
    a = real'(z_in) / UNIT;
    e.m = m;
    e.x = m ? G * $sqrt(rx * rx + ry * ry) : G * (rx * $cos(a) - ry * $sin(a));
    e.y = m ? 0.0 : G * (rx * $sin(a) + ry * $cos(a));
    e.z = m ? wrap(real'(z_in) + $atan2(ry, rx) * UNIT) : 0.0;
    e.txy = txy;
    e.tz = tz;
    e.t = cyc;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic rnd(input bit m);
    int x, y;
    real mag;
    do begin
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
      mag = $sqrt(real'(x) * x + real'(y) * y);
    end while (m && mag < 8000.0);
    issue(m, x, y, int'($urandom_range(0, 65535)) - 32768,
          TS * 12.0 + 6.0e-4 * G * mag, m ? 4.0 + 20000.0 / mag : 2.0);
  endtask
  always @(negedge clock)
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious_out_valid", 1'b0, 1.0, 0.0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc - e.t == L, real'(cyc - e.t), real'(L));
        chk("mode_out", mode_out == e.m, real'(mode_out), real'(e.m));
        chk("x_out", absr(real'(x_out) - e.x) <= e.txy, real'(x_out), e.x);
        chk("y_out", absr(real'(y_out) - e.y) <= e.txy, real'(y_out), e.y);
        chk("z_out", absr(wrap(real'(z_out) - e.z)) <= e.tz, real'(z_out), e.z);
      end
    end
  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", out_valid == 1'b0, real'(out_valid), 0.0);
    chk("reset_x_out", x_out == 0, real'(x_out), 0.0);
    chk("reset_y_out", y_out == 0, real'(y_out), 0.0);
    chk("reset_z_out", z_out == 0, real'(z_out), 0.0);
    reset = 0;
    issue(0, 10000, 0, 'h2000, 4.0 * TS, 2.0);
    idle(L + 2);
    issue(0, 10000, 0, 'h6000, 4.0 * TS, 2.0);
    idle(2);
    issue(0, 10000, 0, -32768, 4.0 * TS, 2.0);
    issue(1, -3000, 4000, 0, 4.0 * TS, 3.0);
    issue(1, -32768, -32768, 0, 8.0 * TS, 3.0);
    idle(L + 2);
    for (int i = 0; i < 40; i++) rnd(i[0]);
    idle(3);
    for (int i = 0; i < 5; i++) rnd(1'($urandom_range(0, 1)));
    idle(L + 2);
    for (int i = 0; i < 10; i++) rnd(i[0]);
    mode = 0;
    x_in = 1234;
    y_in = -4321;
    z_in = 'h1111;
    in_valid = 1;
    reset = 1;
    @(posedge clock);
    sb.delete();
    #1;
    reset = 0;
    in_valid = 0;
    chk("post_reset_out_valid", out_valid == 1'b0, real'(out_valid), 0.0);
    chk("post_reset_mode_out", mode_out == 1'b0, real'(mode_out), 0.0);
    chk("post_reset_x_out", x_out == 0, real'(x_out), 0.0);
    chk("post_reset_y_out", y_out == 0, real'(y_out), 0.0);
    chk("post_reset_z_out", z_out == 0, real'(z_out), 0.0);
    issue(0, 5000, -7000, 'h1234, 6.0 * TS, 2.0);
    idle(L + 2);
    for (int i = 0; i < 300; i++) begin
      rnd(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(L + 4);
    chk("scoreboard_drained", sb.size() == 0, real'(sb.size()), 0.0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
